// File: rtl/axis_packet_router.sv
// AXI-Stream packet router: pairs each packet with a destination from an
// address FIFO and forwards it with tdest, or drops it when out of range.
module axis_packet_router #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int DEST_WIDTH = 32,
  parameter int NUM_DEST   = 4,
  parameter int ADDR_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_packet_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_packet_axis_tkeep,
  input  logic                  s_packet_axis_tvalid,
  input  logic                  s_packet_axis_tlast,
  output logic                  s_packet_axis_tready,
  input  logic [DEST_WIDTH-1:0] s_addr_axis_tdata,
  input  logic                  s_addr_axis_tvalid,
  output logic                  s_addr_axis_tready,
  output logic [DATA_WIDTH-1:0] m_packet_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_packet_axis_tkeep,
  output logic                  m_packet_axis_tvalid,
  output logic                  m_packet_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_packet_axis_tdest,
  input  logic                  m_packet_axis_tready,
  input  logic                  drop_all,
  output logic [31:0]           fwd_count,
  output logic [31:0]           drop_count
);

  localparam int PW = $clog2(ADDR_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FORWARD,
    DROP
  } state_t;

  state_t                state_q, state_d;
  logic [DEST_WIDTH-1:0] mem_q [ADDR_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  addr_rdy_q, addr_rdy_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic [31:0]           fwd_q, fwd_d;
  logic [31:0]           drop_q, drop_d;

  logic                  wr;
  logic                  rd;
  logic                  empty;
  logic                  eop;
  logic [DEST_WIDTH-1:0] head;

  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign wr    = s_addr_axis_tvalid && addr_rdy_q;
  assign rd    = (state_q == IDLE) && !empty;
  assign eop   = s_packet_axis_tvalid && s_packet_axis_tready
               && s_packet_axis_tlast;

  assign s_addr_axis_tready  = addr_rdy_q;
  assign m_packet_axis_tdata = s_packet_axis_tdata;
  assign m_packet_axis_tkeep = s_packet_axis_tkeep;
  assign m_packet_axis_tlast = s_packet_axis_tlast;
  assign m_packet_axis_tdest = dest_q;
  assign fwd_count           = fwd_q;
  assign drop_count          = drop_q;

  always_comb begin
    s_packet_axis_tready = 1'b0;
    m_packet_axis_tvalid = 1'b0;
    unique case (state_q)
      FORWARD: begin
        s_packet_axis_tready = m_packet_axis_tready;
        m_packet_axis_tvalid = s_packet_axis_tvalid;
      end
      DROP: s_packet_axis_tready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dest_d   = dest_q;
    fwd_d    = fwd_q;
    drop_d   = drop_q;
    if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + CW'(wr) - CW'(rd);
    // Ready is registered so it stays low throughout reset.
    addr_rdy_d = (cnt_d != CW'(ADDR_DEPTH));
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          dest_d = head;
          if (head >= DEST_WIDTH'(NUM_DEST) || drop_all)
            state_d = DROP;
          else
            state_d = FORWARD;
        end
      end
      FORWARD: begin
        if (eop) begin
          state_d = IDLE;
          if (fwd_q != '1) fwd_d = fwd_q + 32'd1;
        end
      end
      DROP: begin
        if (eop) begin
          state_d = IDLE;
          if (drop_q != '1) drop_d = drop_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      addr_rdy_q <= 1'b0;
      dest_q     <= '0;
      fwd_q      <= '0;
      drop_q     <= '0;
      for (int i = 0; i < ADDR_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      addr_rdy_q <= addr_rdy_d;
      dest_q     <= dest_d;
      fwd_q      <= fwd_d;
      drop_q     <= drop_d;
      if (wr) mem_q[wr_ptr_q] <= s_addr_axis_tdata;
    end
  end

endmodule

// File: doc/axis_packet_router.md
AXIS_PACKET_ROUTER -- requirements
Module: axis_packet_router

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: packet data width in bits (multiple of 8).
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: tkeep width.
REQ-003 SHALL have parameter DEST_WIDTH, default 32: address/tdest width.
REQ-004 SHALL have parameter NUM_DEST, default 4: valid destinations are 0..NUM_DEST-1.
REQ-005 SHALL have parameter ADDR_DEPTH, default 4: address FIFO depth (power of 2, >=2).
REQ-006 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-008 SHALL have ports s_packet_axis_tdata/tkeep/tvalid/tlast  input  DATA_WIDTH/KEEP_WIDTH/1/1, and s_packet_axis_tready  output  1: packet stream in.
REQ-009 SHALL have ports s_addr_axis_tdata/tvalid  input  DEST_WIDTH/1, and s_addr_axis_tready  output  1: one destination per packet.
REQ-010 SHALL have ports m_packet_axis_tdata/tkeep/tvalid/tlast/tdest  output  DATA_WIDTH/KEEP_WIDTH/1/1/DEST_WIDTH, and m_packet_axis_tready  input  1: routed stream out.
REQ-011 SHALL have port drop_all  input  1  when 1, every packet starting afterwards is dropped.
REQ-012 SHALL have ports fwd_count, drop_count  output  32  saturating packet counters.

Function
REQ-013 Address FIFO: s_addr_axis_tready = not full; write on tvalid&&tready; full/empty flags from a count of 0..ADDR_DEPTH.
REQ-014 Full FIFO SHALL refuse writes even in a cycle in which it is read (no write-through); empty FIFO SHALL not be read.
REQ-015 FSM states IDLE, FORWARD, DROP; reset state IDLE.
REQ-016 IDLE: s_packet_axis_tready=0, m_packet_axis_tvalid=0; if FIFO non-empty, pop head into dest_reg and go next cycle to DROP when (head >= NUM_DEST) or drop_all=1, else FORWARD.
REQ-017 Decision latency: exactly 1 cycle from IDLE with non-empty FIFO to FORWARD/DROP; drop_all sampled only in that IDLE cycle.
REQ-018 FORWARD: m_packet tdata/tkeep/tlast = s_packet inputs combinationally; m_tvalid = s_tvalid; s_tready = m_tready; m_tdest = dest_reg (stable for whole packet).
REQ-019 DROP: s_packet_axis_tready=1, m_packet_axis_tvalid=0; beats consumed and discarded.
REQ-020 A beat with tvalid&&tready&&tlast SHALL end the packet: return to IDLE next cycle; increment fwd_count (FORWARD) or drop_count (DROP).
REQ-021 Single-beat packets SHALL work; back-to-back packets incur one IDLE cycle each (max throughput N/(N+1) beats per cycle for N-beat packets).
REQ-022 Counters SHALL saturate at 0xFFFFFFFF and not wrap.
REQ-023 No beat of s_packet SHALL be accepted outside FORWARD/DROP; a packet with no address waits (tready=0) indefinitely.
REQ-024 Address comparison SHALL be unsigned over full DEST_WIDTH.

Reset
REQ-025 While rst=0: state IDLE, FIFO empty, dest_reg=0, counters=0, s_packet_axis_tready=0, s_addr_axis_tready=0, m_packet_axis_tvalid=0, m_packet_axis_tdest=0.
REQ-026 Reset mid-packet SHALL abandon the packet; after release the remaining beats are treated as a new packet needing a new address.
REQ-027 s_addr_axis_tready SHALL go 1 the first cycle after rst deasserts.

Verification
REQ-028 Address 2, 3-beat packet, m_tready=1 -> 3 output beats, tdest=2, tlast on beat 3, fwd_count=1.
REQ-029 Address 7 (NUM_DEST=4), 4-beat packet -> no m_tvalid, s_tready=1 all 4 beats, drop_count=1.
REQ-030 Push 5 addresses with no packets (ADDR_DEPTH=4) -> 4 accepted, s_addr_axis_tready=0 on the 5th until a packet completes.
REQ-031 Addresses 0,1; two packets; m_tready toggled randomly -> data ordered and unaltered, tdest 0 then 1, one IDLE cycle between.
REQ-032 drop_all=1 at decision for address 1 -> packet dropped; drop_all=0 for next -> forwarded.
REQ-033 rst=0 on beat 2 of 4 -> all outputs reset values REQ-025, counters 0, FIFO empty.
